countdown_scheduler: RTL and testbench
======================================

Name: countdown_scheduler

Overview:
Shares one down-counting timer between NREQ requesters. Each requester presents a start value and holds a request. A round-robin arbiter grants the timer to one requester, which loads the value and counts down to 0. The granted requester then gets a one-cycle done pulse. The block sits between lab client logic and the shared countdown datapath.

Parameters:
NREQ, 4, number of requesters (≥2)
DW, 8, counter and load-value width in bits (unsigned)

Ports:
clk  input  1  single clock; all state changes on posedge
reset  input  1  asynchronous, active-low (0 = reset)
req  input  NREQ  level request; req[i] held until done[i] is seen, or dropped to abort
load_val  input  NREQ*DW  start values; slot i at [i*DW +: DW]
pause  input  1  global hold; while 1, an active countdown freezes
grant  output  NREQ  one-hot owner of the timer; 0 when idle
busy  output  1  1 while the timer is owned (COUNT or DONE)
count  output  DW  current timer value
done  output  NREQ  one-hot, one-cycle completion pulse to the owner

Behaviour:
- Reset (reset==0, asynchronous, no clock needed):
  - state=IDLE, grant=0, busy=0, count=0, done=0.
  - Round-robin pointer ptr=0, so req[0] has highest priority.
- FSM states: IDLE, COUNT, DONE. All outputs are registered.
- IDLE, no req bit set: hold. count keeps its last value.
- IDLE, any req bit set at the edge:
  - sel = first set bit scanning ptr, ptr+1, … mod NREQ.
  - Next state COUNT, grant=onehot(sel), busy=1, count=load_val slot sel.
  - ptr=(sel+1) mod NREQ, so the last winner gets lowest priority next time.
- COUNT, priority order:
  1. req[sel]==0: abort. Next IDLE, grant=0, busy=0, no done pulse, count holds.
  2. pause==1: hold everything.
  3. count!=0: count=count-1.
  4. count==0: next DONE, done=onehot(sel). grant and busy stay 1.
- DONE (exactly one cycle): next IDLE, done=0, grant=0, busy=0, count stays 0. req and pause are ignored in DONE.
- load_val is sampled only at the granting edge; later changes are ignored.
- Requests from non-owners during COUNT/DONE are ignored until IDLE.
- If req[sel] is still high in IDLE, it is re-arbitrated at its rotated (lowest) priority.
- Arithmetic: count never goes below 0, so there is no wrap. load_val=0 is legal: it gives one COUNT cycle at 0, then DONE.
- Latency with no pause and start value L, counting edges from E0 (grant edge):
  - count=L after E0 and reaches 0 after E_L.
  - done is high between E(L+1) and E(L+2).
  - Back in IDLE after E(L+2).
  - Minimum job-to-job spacing is L+3 cycles.
- Reset mid-operation: the job is dropped with no done pulse. State returns to reset values immediately.

Decomposition:
- Package cd_sched_pkg holds:
  - state enum typedef: IDLE, COUNT, DONE.
  - default parameter constants.
  - a function rr_pick(req, ptr) that returns sel and a found flag.
- One sub-module, cd_timer: loadable down counter with ports clk, reset, load, load_val, dec, count, zero.
  - Async active-low reset.
  - load has priority over dec.
  - Instantiated once.
- The FSM, arbiter and grant/done registers live in countdown_scheduler.

Test Plan:
1. req=0001, slot0=5, pause=0 → next edge grant=0001, busy=1, count=5. count steps 4,3,2,1,0. done=0001 for one cycle at E6. grant=0, busy=0 after E7.
2. req=0101 together, slot0=3, slot2=2, ptr=0, both held until their own done:
   - req0 served first; done=0001 at E4.
   - IDLE after E5.
   - req2 granted at E6, count=2.
   - req0 (still high) is not granted until req2's done.
3. Single job, slot=6, pause=1 for 3 cycles while count=4 → count holds 4 for those 3 cycles. done arrives 3 cycles later than in scenario 1 timing.
4. req=0010, slot1=9; drop req[1] when count=2 → next edge IDLE, grant=0, busy=0, count stays 2, done never pulses.
5. req=1000, slot3=0 → grant=1000, count=0 after E0. done=1000 at E1. IDLE after E2.
6. reset driven 0 mid-edge during COUNT with count=7 → grant, busy, count and done go to 0 before the next clk edge. After release, req=1111 grants req[0] (ptr reset to 0).

Source files
------------

// File: rtl/cd_sched_pkg.sv
// cd_sched_pkg: shared state type, defaults and round-robin picker for countdown_scheduler.
package cd_sched_pkg;

    typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

    localparam int NREQ_DEF = 4;
    localparam int DW_DEF   = 8;
    localparam int MAXN     = 32;

    typedef struct packed {
        logic       found;
        logic [4:0] sel;
    } pick_t;

    // First set bit of req scanning ptr, ptr+1, ... wrapping at n; lowest offset wins.
    function automatic pick_t rr_pick(input logic [MAXN-1:0] req, input int n, input int ptr);
        pick_t p;
        int idx;
        p = '0;
        for (int k = MAXN - 1; k >= 0; k--) begin
            if (k < n) begin
                idx = ptr + k;
                if (idx >= n) idx -= n;
                if (req[idx]) begin
                    p.found = 1'b1;
                    p.sel   = 5'(idx);
                end
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/cd_timer.sv
// cd_timer: loadable down counter that saturates at zero; load wins over dec.
module cd_timer #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [DW-1:0] load_val,
    input  logic          dec,
    output logic [DW-1:0] count,
    output logic          zero
);

    logic [DW-1:0] r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_count <= '0;
        else if (load)
            r_count <= load_val;
        else if (dec && r_count != '0)
            r_count <= r_count - 1'b1;
    end

    assign count = r_count;
    assign zero  = r_count == '0;

endmodule

// File: rtl/countdown_scheduler.sv
// countdown_scheduler: round-robin shares one countdown timer among NREQ requesters,
// pulsing done to the owner when its count reaches zero.
module countdown_scheduler
    import cd_sched_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int DW   = DW_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] load_val,
    input  logic             pause,
    output logic [NREQ-1:0]  grant,
    output logic             busy,
    output logic [DW-1:0]    count,
    output logic [NREQ-1:0]  done
);

    localparam int PW = $clog2(NREQ);

    state_t          r_state;
    logic [NREQ-1:0] r_grant;
    logic [NREQ-1:0] r_done;
    logic            r_busy;
    logic [PW-1:0]   r_ptr;
    logic [PW-1:0]   r_sel;

    pick_t           w_pick;
    logic [PW-1:0]   w_sel;
    logic            w_load;
    logic            w_dec;
    logic            w_zero;

    assign w_pick = rr_pick(MAXN'(req), NREQ, int'(r_ptr));
    assign w_sel  = PW'(w_pick.sel);
    assign w_load = r_state == IDLE && w_pick.found;
    assign w_dec  = r_state == COUNT && req[r_sel] && !pause;

    cd_timer #(.DW(DW)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (w_load),
        .load_val (load_val[w_sel*DW +: DW]),
        .dec      (w_dec),
        .count    (count),
        .zero     (w_zero)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_done  <= '0;
            r_busy  <= 1'b0;
            r_ptr   <= '0;
            r_sel   <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_pick.found) begin
                    r_state <= COUNT;
                    r_grant <= NREQ'(1) << w_sel;
                    r_busy  <= 1'b1;
                    r_sel   <= w_sel;
                    r_ptr   <= (w_sel == PW'(NREQ - 1)) ? '0 : w_sel + 1'b1;
                end
                // An abort outranks pause so a dropped request always releases the timer.
                COUNT: if (!req[r_sel]) begin
                    r_state <= IDLE;
                    r_grant <= '0;
                    r_busy  <= 1'b0;
                end else if (!pause && w_zero) begin
                    r_state <= DONE;
                    r_done  <= r_grant;
                end
                default: begin
                    r_state <= IDLE;
                    r_done  <= '0;
                    r_grant <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign grant = r_grant;
    assign busy  = r_busy;
    assign done  = r_done;

endmodule

// File: tb/tb_countdown_scheduler.sv
// tb_countdown_scheduler: directed scenarios plus randomized traffic checked every cycle
// against a job-level model of the shared timer.
module tb_countdown_scheduler;

    localparam int N  = 4;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N*DW-1:0] load_val = '0;
    logic            pause = 1'b0;
    logic [N-1:0]    grant;
    logic            busy;
    logic [DW-1:0]   count;
    logic [N-1:0]    done;

    int checks = 0;
    int errors = 0;

    // Model: who owns the timer (-1 = nobody), its remaining count, and whether this is the done cycle.
    int m_owner = -1;
    int m_cnt   = 0;
    int m_ptr   = 0;
    bit m_done  = 1'b0;

    countdown_scheduler #(.NREQ(N), .DW(DW)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .load_val (load_val),
        .pause    (pause),
        .grant    (grant),
        .busy     (busy),
        .count    (count),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    function automatic void mreset();
        m_owner = -1;
        m_cnt   = 0;
        m_ptr   = 0;
        m_done  = 1'b0;
    endfunction

    function automatic void mstep();
        bit found;
        int idx;
        found = 1'b0;
        if (m_done) begin
            m_done  = 1'b0;
            m_owner = -1;
        end else if (m_owner < 0) begin
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (!found && req[idx]) begin
                    found   = 1'b1;
                    m_owner = idx;
                    m_cnt   = int'(load_val[idx*DW +: DW]);
                    m_ptr   = (idx + 1) % N;
                end
            end
        end else if (!req[m_owner]) begin
            m_owner = -1;
        end else if (!pause) begin
            if (m_cnt > 0) m_cnt--;
            else m_done = 1'b1;
        end
    endfunction

    initial forever begin
        @(negedge reset);
        mreset();
    end

    initial forever begin
        @(posedge clk);
        if (reset) mstep();
        #1;
        if (reset) begin
            chk("model_grant", 32'(grant), m_owner >= 0 ? 32'(1) << m_owner : 32'd0);
            chk("model_busy",  32'(busy),  32'(m_owner >= 0));
            chk("model_count", 32'(count), 32'(m_cnt));
            chk("model_done",  32'(done),  m_done ? 32'(1) << m_owner : 32'd0);
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic setv(input int i, input int v);
        load_val[i*DW +: DW] = DW'(v);
    endtask

    task automatic rst_pulse();
        req   = '0;
        pause = 1'b0;
        reset = 1'b0;
        #2;
        reset = 1'b1;
    endtask

    initial begin
        #3;
        chk("reset_grant", 32'(grant), 0);
        chk("reset_busy",  32'(busy),  0);
        chk("reset_count", 32'(count), 0);
        chk("reset_done",  32'(done),  0);
        reset = 1'b1;
        cyc(1);

        // Single job of 5
        rst_pulse();
        req = 4'b0001; setv(0, 5);
        cyc(1);
        chk("s1_grant", 32'(grant), 1);
        chk("s1_busy",  32'(busy),  1);
        chk("s1_load",  32'(count), 5);
        for (int v = 4; v >= 0; v--) begin
            cyc(1);
            chk("s1_count", 32'(count), 32'(v));
        end
        cyc(1);
        chk("s1_done", 32'(done), 1);
        req = '0;
        cyc(1);
        chk("s1_idle_grant", 32'(grant), 0);
        chk("s1_idle_busy",  32'(busy),  0);
        chk("s1_idle_done",  32'(done),  0);

        // Two simultaneous requests, round-robin order
        rst_pulse();
        req = 4'b0101; setv(0, 3); setv(2, 2);
        cyc(1);
        chk("s2_grant0", 32'(grant), 1);
        chk("s2_load0",  32'(count), 3);
        cyc(4);
        chk("s2_done0", 32'(done), 1);
        req[0] = 1'b0;
        cyc(1);
        chk("s2_idle", 32'(grant), 0);
        req[0] = 1'b1;
        cyc(1);
        chk("s2_grant2", 32'(grant), 4);
        chk("s2_load2",  32'(count), 2);
        cyc(2);
        chk("s2_hold2", 32'(grant), 4);
        cyc(1);
        chk("s2_done2", 32'(done), 4);
        req[2] = 1'b0;
        cyc(2);
        chk("s2_regrant0", 32'(grant), 1);
        chk("s2_reload0",  32'(count), 3);
        req = '0;
        cyc(2);

        // Pause for three cycles at count 4
        rst_pulse();
        req = 4'b0001; setv(0, 6);
        cyc(1);
        chk("s3_load", 32'(count), 6);
        cyc(2);
        chk("s3_at4", 32'(count), 4);
        pause = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            chk("s3_paused", 32'(count), 4);
        end
        pause = 1'b0;
        cyc(4);
        chk("s3_zero",    32'(count), 0);
        chk("s3_no_done", 32'(done),  0);
        cyc(1);
        chk("s3_done", 32'(done), 1);
        req = '0;
        cyc(1);

        // Abort at count 2
        rst_pulse();
        req = 4'b0010; setv(1, 9);
        cyc(1);
        chk("s4_grant", 32'(grant), 2);
        cyc(7);
        chk("s4_at2", 32'(count), 2);
        req = '0;
        cyc(1);
        chk("s4_grant_off", 32'(grant), 0);
        chk("s4_busy_off",  32'(busy),  0);
        for (int i = 0; i < 3; i++) begin
            chk("s4_count_hold", 32'(count), 2);
            chk("s4_no_done",    32'(done),  0);
            cyc(1);
        end

        // Zero start value
        rst_pulse();
        req = 4'b1000; setv(3, 0);
        cyc(1);
        chk("s5_grant", 32'(grant), 8);
        chk("s5_count", 32'(count), 0);
        chk("s5_early", 32'(done),  0);
        cyc(1);
        chk("s5_done", 32'(done), 8);
        chk("s5_busy", 32'(busy), 1);
        req = '0;
        cyc(1);
        chk("s5_idle_grant", 32'(grant), 0);
        chk("s5_idle_busy",  32'(busy),  0);

        // Asynchronous reset mid-count, then pointer back at 0
        rst_pulse();
        req = 4'b0001; setv(0, 7); setv(1, 4); setv(2, 5); setv(3, 6);
        cyc(1);
        chk("s6_count", 32'(count), 7);
        #3 reset = 1'b0;
        #1;
        chk("s6_async_grant", 32'(grant), 0);
        chk("s6_async_busy",  32'(busy),  0);
        chk("s6_async_count", 32'(count), 0);
        chk("s6_async_done",  32'(done),  0);
        #1 reset = 1'b1;
        req = 4'b1111;
        cyc(1);
        chk("s6_regrant", 32'(grant), 1);
        chk("s6_reload",  32'(count), 7);
        req = '0;
        cyc(2);

        // Randomized traffic against the model
        rst_pulse();
        for (int c = 0; c < 3000; c++) begin
            cyc(1);
            for (int i = 0; i < N; i++) begin
                if (req[i]) begin
                    if ((m_done && m_owner == i) || $urandom_range(0, 39) == 0) req[i] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    req[i] = 1'b1;
                end
                setv(i, int'($urandom_range(0, 15)));
            end
            pause = $urandom_range(0, 7) == 0;
        end
        req = '0;
        cyc(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
